// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Shares one ALU (alu_ctrl decode + alu_core datapath) between two
//   requesters. One operation is in flight at a time: accept, execute for one
//   cycle, then hold the registered response until the consumer takes it.
//
// Ports (alu_arbiter)
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   reqN_valid     requester N presents an operation (N = 0, 1)
//   reqN_ready     requester N operation accepted this cycle (combinational)
//   reqN_a/b       operands of requester N
//   reqN_funct3/7  RISC-V R-type function fields of requester N
//   rsp_valid      response held on rsp_* outputs
//   rsp_ready      consumer accepts the response
//   rsp_id         requester that owns the response
//   rsp_result     registered ALU result
//   rsp_zero       registered result == 0
//   rsp_overflow   registered signed overflow (ADD/SUB only)
//   busy           high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// alu_ctrl
//   Maps the R-type function fields onto the core opcode {alt, funct3}.
//   alt is funct7[5]; combinations the core has no special meaning for are
//   passed straight through, so the core simply computes what the bits say.
// Ports
//   funct3, funct7  function fields
//   alu_op          {alt, funct3}
// ---------------------------------------------------------------------------
module alu_ctrl (
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_op
);

  // Only the alternate-encoding bit selects anything in the core.
  logic unused_funct7;

  assign alu_op        = {funct7[5], funct3};
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

endmodule

// ---------------------------------------------------------------------------
// alu_core
//   Combinational RV32I-style integer datapath.
//   funct3: 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR,
//           101 SRL/SRA, 110 OR, 111 AND; alt selects SUB and SRA.
// Ports
//   a, b       operands
//   alu_op     {alt, funct3} from alu_ctrl
//   result     operation result
//   zero       result == 0
//   overflow   signed overflow of ADD/SUB, 0 for every other operation
// ---------------------------------------------------------------------------
module alu_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  localparam int SHW = $clog2(WIDTH);

  logic             alt;
  logic [2:0]       f3;
  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;
  logic             add_ovf;
  logic             sub_ovf;
  logic             lt_s;
  logic             lt_u;
  logic [SHW-1:0]   shamt;

  assign alt     = alu_op[3];
  assign f3      = alu_op[2:0];
  assign add_res = a + b;
  assign sub_res = a - b;
  assign shamt   = b[SHW-1:0];
  assign lt_s    = $signed(a) < $signed(b);
  assign lt_u    = a < b;

  // Signed overflow: operands agree in sign (ADD) or differ (SUB) and the
  // result sign differs from a.
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_res[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_res[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (f3)
      3'b000: begin
        result   = alt ? sub_res : add_res;
        overflow = alt ? sub_ovf : add_ovf;
      end
      3'b001:  result = a << shamt;
      3'b010:  result = {{(WIDTH-1){1'b0}}, lt_s};
      3'b011:  result = {{(WIDTH-1){1'b0}}, lt_u};
      3'b100:  result = a ^ b;
      3'b101:  result = alt ? WIDTH'($signed(a) >>> shamt) : (a >> shamt);
      3'b110:  result = a | b;
      default: result = a & b;
    endcase
  end

  assign zero = (result == '0);

endmodule

// ---------------------------------------------------------------------------
// alu_arbiter top
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting; grants one valid requester and captures its operands
//   EXEC  | ALU runs on captured operands; result latched into rsp_*
//   RESP  | rsp_valid high, rsp_* frozen until rsp_ready
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int WIDTH     = 32,
  parameter int PRIO_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_funct3,
  input  logic [6:0]       req0_funct7,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_funct3,
  input  logic [6:0]       req1_funct7,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic             last_grant;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [2:0]       op_funct3;
  logic [6:0]       op_funct7;
  logic             op_id;

  logic             any_valid;
  logic             gnt_id;
  logic             accept;

  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             alu_overflow;

  // ---- arbitration --------------------------------------------------------
  assign any_valid = req0_valid | req1_valid;

  always_comb begin
    gnt_id = 1'b0;
    if (PRIO_MODE == 1) begin
      gnt_id = ~req0_valid;
    end else if (req0_valid && req1_valid) begin
      gnt_id = ~last_grant;
    end else begin
      gnt_id = req1_valid;
    end
  end

  // rst gates accept so no requester believes it was taken during reset.
  assign accept     = (state == IDLE) && any_valid && !rst;
  assign req0_ready = accept && !gnt_id;
  assign req1_ready = accept &&  gnt_id;
  assign busy       = (state != IDLE);

  // ---- shared ALU, fed only from the captured operands --------------------
  alu_ctrl u_alu_ctrl (
    .funct3 (op_funct3),
    .funct7 (op_funct7),
    .alu_op (alu_op)
  );

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu_core (
    .a        (op_a),
    .b        (op_b),
    .alu_op   (alu_op),
    .result   (alu_result),
    .zero     (alu_zero),
    .overflow (alu_overflow)
  );

  // ---- FSM and datapath registers -----------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      op_a         <= '0;
      op_b         <= '0;
      op_funct3    <= '0;
      op_funct7    <= '0;
      op_id        <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a       <= gnt_id ? req1_a      : req0_a;
            op_b       <= gnt_id ? req1_b      : req0_b;
            op_funct3  <= gnt_id ? req1_funct3 : req0_funct3;
            op_funct7  <= gnt_id ? req1_funct7 : req0_funct7;
            op_id      <= gnt_id;
            last_grant <= gnt_id;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_result   <= alu_result;
          rsp_zero     <= alu_zero;
          rsp_overflow <= alu_overflow;
          rsp_id       <= op_id;
          rsp_valid    <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//   Directed bench for alu_arbiter. Two instances share every input: u_rr
//   uses round-robin, u_fp uses fixed priority to requester 0.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_funct3, req1_funct3;
  logic [6:0]  req0_funct7, req1_funct7;
  logic        rsp_ready;

  logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_zero, rsp_overflow, busy;
  logic [31:0] rsp_result;
  logic        req0_ready_p, req1_ready_p, rsp_valid_p, rsp_id_p, rsp_zero_p, rsp_overflow_p, busy_p;
  logic [31:0] rsp_result_p;

  int errors = 0;
  int total  = 0;
  int cyc    = 0;
  int t0;
  int exp_rr [4] = '{0, 1, 0, 1};
  int exp_rs [4] = '{2, 4, 2, 4};

  // op vectors for the datapath section: a, b, funct3, funct7, result, zero, ovf
  logic [31:0] va [7] = '{32'h7FFFFFFF, 32'h5, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h2};
  logic [31:0] vb [7] = '{32'h1, 32'hFFFFFFFB, 32'h1, 32'h4, 32'h1, 32'h1, 32'h3};
  logic [2:0]  vf3[7] = '{3'd0, 3'd0, 3'd0, 3'd5, 3'd2, 3'd3, 3'd0};
  logic [6:0]  vf7[7] = '{7'h00, 7'h00, 7'h20, 7'h20, 7'h00, 7'h00, 7'h01};
  logic [31:0] vr [7] = '{32'h80000000, 32'h0, 32'h7FFFFFFF, 32'hF8000000, 32'h1, 32'h0, 32'h5};
  logic        vz [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic        vo [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter #(.WIDTH(32), .PRIO_MODE(0)) u_rr (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_funct3(req0_funct3), .req0_funct7(req0_funct7),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_funct3(req1_funct3), .req1_funct7(req1_funct7),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow), .busy(busy)
  );

  alu_arbiter #(.WIDTH(32), .PRIO_MODE(1)) u_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready_p), .req0_a(req0_a), .req0_b(req0_b),
    .req0_funct3(req0_funct3), .req0_funct7(req0_funct7),
    .req1_valid(req1_valid), .req1_ready(req1_ready_p), .req1_a(req1_a), .req1_b(req1_b),
    .req1_funct3(req1_funct3), .req1_funct7(req1_funct7),
    .rsp_valid(rsp_valid_p), .rsp_ready(rsp_ready), .rsp_id(rsp_id_p), .rsp_result(rsp_result_p),
    .rsp_zero(rsp_zero_p), .rsp_overflow(rsp_overflow_p), .busy(busy_p)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp(input string tag, input int lim);
    int n = 0;
    while (!rsp_valid && n < lim) begin
      step();
      n++;
    end
    chk(tag, {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic set0(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] f3, input logic [6:0] f7);
    req0_valid = v; req0_a = a; req0_b = b; req0_funct3 = f3; req0_funct7 = f7;
  endtask

  task automatic set1(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] f3, input logic [6:0] f7);
    req1_valid = v; req1_a = a; req1_b = b; req1_funct3 = f3; req1_funct7 = f7;
  endtask

  initial begin
    // ---- reset: ready stays low even with both valid -----------------------
    rst = 1'b1;
    rsp_ready = 1'b1;
    set0(1'b1, 32'd1, 32'd1, 3'd0, 7'h00);
    set1(1'b1, 32'd1, 32'd1, 3'd0, 7'h00);
    step();
    chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
    chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
    step();
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_id",    {31'd0, rsp_id}, 32'd0);
    chk("rst_result",    rsp_result, 32'd0);
    chk("rst_zero",      {31'd0, rsp_zero}, 32'd0);
    chk("rst_ovf",       {31'd0, rsp_overflow}, 32'd0);
    chk("rst_busy",      {31'd0, busy}, 32'd0);

    // ---- single ADD 5+3, latency T+2, operands changed after accept --------
    set0(1'b1, 32'd5, 32'd3, 3'd0, 7'h00);
    #1;
    chk("add_ready0", {31'd0, req0_ready}, 32'd1);
    chk("add_ready1", {31'd0, req1_ready}, 32'd0);
    t0 = cyc;
    step();
    req0_valid = 1'b0;
    req0_a = 32'hDEAD_BEEF;
    #1;
    chk("exec_busy",      {31'd0, busy}, 32'd1);
    chk("exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    step();
    chk("add_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("add_latency",   cyc - t0, 32'd2);
    chk("add_id",        {31'd0, rsp_id}, 32'd0);
    chk("add_result",    rsp_result, 32'd8);
    chk("add_zero",      {31'd0, rsp_zero}, 32'd0);
    step();

    // ---- contention after reset: SUB on req0 wins, then XOR on req1 ---------
    rst = 1'b1;
    step();
    rst = 1'b0;
    set0(1'b1, 32'd5, 32'd3, 3'd0, 7'h20);
    set1(1'b1, 32'hF0F0F0F0, 32'h0F0F0F0F, 3'd4, 7'h00);
    #1;
    chk("cont_ready0", {31'd0, req0_ready}, 32'd1);
    chk("cont_ready1", {31'd0, req1_ready}, 32'd0);
    step();
    req0_valid = 1'b0;
    #1;
    chk("cont_exec_ready1", {31'd0, req1_ready}, 32'd0);
    step();
    chk("cont_id0",     {31'd0, rsp_id}, 32'd0);
    chk("cont_result0", rsp_result, 32'd2);
    step();
    chk("cont_ready1_later", {31'd0, req1_ready}, 32'd1);
    step();
    req1_valid = 1'b0;
    wait_rsp("cont_rsp1_timeout", 4);
    chk("cont_id1",     {31'd0, rsp_id}, 32'd1);
    chk("cont_result1", rsp_result, 32'hFFFFFFFF);
    step();

    // ---- both continuously valid for 4 ops ---------------------------------
    set0(1'b1, 32'd1, 32'd1, 3'd0, 7'h00);
    set1(1'b1, 32'd2, 32'd2, 3'd0, 7'h00);
    for (int k = 0; k < 4; k++) begin
      wait_rsp($sformatf("stream%0d_timeout", k), 4);
      chk($sformatf("rr_id%0d", k),     {31'd0, rsp_id}, exp_rr[k]);
      chk($sformatf("rr_res%0d", k),    rsp_result, exp_rs[k]);
      chk($sformatf("fp_id%0d", k),     {31'd0, rsp_id_p}, 32'd0);
      chk($sformatf("fp_res%0d", k),    rsp_result_p, 32'd2);
      if (k == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      step();
    end

    // ---- backpressure: rsp_ready low for 5 RESP cycles ---------------------
    rsp_ready = 1'b0;
    set0(1'b1, 32'd10, 32'd20, 3'd0, 7'h00);
    #1;
    chk("bp_ready0", {31'd0, req0_ready}, 32'd1);
    step();
    req0_valid = 1'b0;
    step();
    set1(1'b1, 32'h000000FF, 32'h0000000F, 3'd4, 7'h00);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp_valid%0d", k),  {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("bp_result%0d", k), rsp_result, 32'd30);
      chk($sformatf("bp_id%0d", k),     {31'd0, rsp_id}, 32'd0);
      chk($sformatf("bp_ready0_%0d", k), {31'd0, req0_ready}, 32'd0);
      chk($sformatf("bp_ready1_%0d", k), {31'd0, req1_ready}, 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    t0 = cyc;
    #1;
    chk("bp_release_ready1", {31'd0, req1_ready}, 32'd0);
    step();
    chk("bp_accept_ready1", {31'd0, req1_ready}, 32'd1);
    chk("bp_accept_delay",  cyc - t0, 32'd1);
    step();
    req1_valid = 1'b0;
    wait_rsp("bp_rsp_timeout", 4);
    chk("bp_id1",     {31'd0, rsp_id}, 32'd1);
    chk("bp_result1", rsp_result, 32'h000000F0);
    step();

    // ---- datapath vectors: overflow, zero, shifts, compares, unsupported ---
    for (int k = 0; k < 7; k++) begin
      set0(1'b1, va[k], vb[k], vf3[k], vf7[k]);
      #1;
      chk($sformatf("dp%0d_ready0", k), {31'd0, req0_ready}, 32'd1);
      step();
      req0_valid = 1'b0;
      wait_rsp($sformatf("dp%0d_timeout", k), 4);
      chk($sformatf("dp%0d_result", k), rsp_result, vr[k]);
      chk($sformatf("dp%0d_zero", k),   {31'd0, rsp_zero}, {31'd0, vz[k]});
      chk($sformatf("dp%0d_ovf", k),    {31'd0, rsp_overflow}, {31'd0, vo[k]});
      step();
    end

    // ---- reset during EXEC discards the op and restores req0 priority ------
    set0(1'b1, 32'd1, 32'd2, 3'd0, 7'h00);
    #1;
    chk("rx_ready0", {31'd0, req0_ready}, 32'd1);
    step();
    req0_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rx_in_exec", {31'd0, busy}, 32'd1);
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rx_no_rsp%0d", k),  {31'd0, rsp_valid}, 32'd0);
      chk($sformatf("rx_idle%0d", k),    {31'd0, busy}, 32'd0);
      step();
    end
    set0(1'b1, 32'd9, 32'd4, 3'd0, 7'h20);
    set1(1'b1, 32'h0000F0F0, 32'h00000FF0, 3'd7, 7'h00);
    #1;
    chk("rx_ready0", {31'd0, req0_ready}, 32'd1);
    chk("rx_ready1", {31'd0, req1_ready}, 32'd0);
    step();
    req0_valid = 1'b0;
    wait_rsp("rx_rsp0_timeout", 4);
    chk("rx_id0",     {31'd0, rsp_id}, 32'd0);
    chk("rx_result0", rsp_result, 32'd5);
    step();
    chk("rx_ready1_later", {31'd0, req1_ready}, 32'd1);
    step();
    req1_valid = 1'b0;
    wait_rsp("rx_rsp1_timeout", 4);
    chk("rx_id1",     {31'd0, rsp_id}, 32'd1);
    chk("rx_result1", rsp_result, 32'h000000F0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, total);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk only.
REQ-002 Parameter WIDTH, default 32, SHALL set the operand/result width and SHALL equal the alu_core datapath width.
REQ-003 Parameter PRIO_MODE, default 0, SHALL select arbitration: 0 = round-robin, 1 = fixed priority to requester 0.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-007 reqN_ready  output  1  requester N operation accepted this cycle.
REQ-008 reqN_a, reqN_b  input  WIDTH  operands of requester N.
REQ-009 reqN_funct3  input  3  and reqN_funct7  input  7  RISC-V R-type function fields of requester N.
REQ-010 rsp_valid  output  1  response is held on rsp_* outputs.
REQ-011 rsp_ready  input  1  consumer accepts the response.
REQ-012 rsp_id  output  1  index of the requester that owns the response.
REQ-013 rsp_result  output  WIDTH; rsp_zero  output  1; rsp_overflow  output  1  registered ALU outputs.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The block SHALL instantiate exactly one alu_ctrl and one alu_core and SHALL share them between both requesters.
REQ-016 The FSM SHALL have the states IDLE, EXEC and RESP.
REQ-017 IDLE: when at least one reqN_valid is high, the block SHALL grant one requester, assert that requester's reqN_ready combinationally in the same cycle, register its a/b/funct3/funct7 and the grant id, and move to EXEC.
REQ-018 reqN_ready SHALL be high only in IDLE, for the granted requester only, and never for both requesters in the same cycle.
REQ-019 Round-robin: with a single valid requester, that requester SHALL be granted; with both valid, the requester other than last_grant SHALL be granted.
REQ-020 Fixed priority: requester 0 SHALL win whenever req0_valid is high.
REQ-021 last_grant SHALL update only when a request is accepted.
REQ-022 EXEC lasts one cycle: the ALU SHALL be driven only from the registered operands, and result/zero/overflow SHALL be latched into the rsp_* registers; the next state is RESP.
REQ-023 RESP: rsp_valid SHALL be high, and all rsp_* outputs SHALL stay stable until the cycle in which rsp_ready is high; the next state is then IDLE.
REQ-024 Latency: a request accepted in cycle T SHALL produce rsp_valid in cycle T+2; the minimum issue interval is 3 cycles.
REQ-025 Requester inputs that change after acceptance SHALL NOT affect the in-flight operation.
REQ-026 A request that is not accepted SHALL NOT be dropped; the requester keeps valid high, and the block serves it in a later IDLE cycle.
REQ-027 funct3/funct7 combinations unsupported by alu_ctrl SHALL pass through unchanged; the response is whatever alu_core produces, and the block SHALL NOT flag an error.

Reset
REQ-028 On rst, the state SHALL become IDLE; rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_overflow, busy, req0_ready and req1_ready SHALL be 0; last_grant SHALL be 1, so that requester 0 wins the first contention.
REQ-029 Reset in EXEC or RESP SHALL discard the in-flight operation; no response for it SHALL ever appear.
REQ-030 While rst is high, reqN_ready SHALL be 0 regardless of reqN_valid.

Verification
REQ-031 req0 ADD a=5, b=3 (funct3=000, funct7=0000000), accepted at T -> rsp_valid=1 at T+2 with rsp_id=0, rsp_result=8, rsp_zero=0.
REQ-032 After reset, req0 SUB 5-3 (funct7=0100000) and req1 XOR F0F0F0F0^0F0F0F0F valid together -> first rsp_id=0 with result 2, second rsp_id=1 with result FFFFFFFF.
REQ-033 Both requesters continuously valid for 4 ops (PRIO_MODE=0) -> rsp_id sequence 0,1,0,1; with PRIO_MODE=1 -> 0,0,0,0.
REQ-034 rsp_ready held low 5 cycles in RESP -> rsp_* unchanged, req0_ready=req1_ready=0 throughout, next accept exactly 1 cycle after rsp_ready rises.
REQ-035 ADD 7FFFFFFF+1 -> result 80000000, overflow=1; ADD 5+FFFFFFFB -> result 0, zero=1.
REQ-036 rst pulsed in EXEC -> rsp_valid stays 0, no response for that op; next contention is granted to req0.
